// File: rtl/sync_fifo_1kx16_if.sv
// Handshake bundle for the 1k x 16 RX sample/command FIFO.
// master drives writes and read requests; slave is the FIFO.
interface sync_fifo_1kx16_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 10
);
  logic [WIDTH-1:0]      data;
  logic                  wrreq;
  logic                  rdreq;
  logic [WIDTH-1:0]      q;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2-1:0] usedw;
  logic                  almost_empty;

  modport master (
    output data, wrreq, rdreq,
    input  q, empty, full, usedw, almost_empty
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, empty, full, usedw, almost_empty
  );
endinterface

// File: rtl/sync_fifo_1kx16.sv
// Single-clock 1024x16 FIFO with count, empty/full/almost-empty flags.
// Define FIFO_SHOWAHEAD_EN to present the head word on q without a read.
module sync_fifo_1kx16 #(
  parameter int WIDTH              = 16,
  parameter int DEPTH_LOG2         = 10,
  parameter int ALMOST_EMPTY_VALUE = 504
) (
  input logic              clock,
  input logic              aclr,
  sync_fifo_1kx16_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_nxt;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  do_wr;
  logic                  do_rd;
  logic                  empty_r;
  logic                  full_r;
  logic                  ae_r;
  logic [WIDTH-1:0]      q_r;

  // Gating on the registered flags gives the full/empty priority rules.
  always_comb begin
    do_wr   = bus.wrreq & ~full_r;
    do_rd   = bus.rdreq & ~empty_r;
    rd_nxt  = rd_ptr + {{(DEPTH_LOG2-1){1'b0}}, do_rd};
    cnt_nxt = cnt
            + {{(CW-1){1'b0}}, do_wr}
            - {{(CW-1){1'b0}}, do_rd};
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ae_r    <= 1'b1;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_nxt;
      cnt     <= cnt_nxt;
      empty_r <= (cnt_nxt == '0);
      full_r  <= (cnt_nxt == CW'(DEPTH));
      ae_r    <= (cnt_nxt < CW'(ALMOST_EMPTY_VALUE));
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr)
      mem[wr_ptr] <= bus.data;
  end

`ifdef FIFO_SHOWAHEAD_EN
  // Prefetch the post-edge head; bypass when it is being written now.
  always_ff @(posedge clock) begin
    if (aclr)
      q_r <= '0;
    else if (do_wr && (wr_ptr == rd_nxt))
      q_r <= bus.data;
    else
      q_r <= mem[rd_nxt];
  end
`else
  always_ff @(posedge clock) begin
    if (aclr)
      q_r <= '0;
    else if (do_rd)
      q_r <= mem[rd_ptr];
  end
`endif

  assign bus.q            = q_r;
  assign bus.empty        = empty_r;
  assign bus.full         = full_r;
  assign bus.usedw        = cnt[DEPTH_LOG2-1:0];
  assign bus.almost_empty = ae_r;
endmodule

// File: tb/tb_sync_fifo_1kx16.sv
// Randomised scoreboard bench for sync_fifo_1kx16.
// Queue model supplies expected data and flags.
module tb_sync_fifo_1kx16;
  logic clock = 1'b0;
  logic aclr;

  sync_fifo_1kx16_if bus ();

  sync_fifo_1kx16 dut (
    .clock (clock),
    .aclr  (aclr),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int unsigned   n_chk  = 0;
  int unsigned   n_pass = 0;
  logic [15:0]   mq [$];
  logic [15:0]   exp_q [$];
  logic [15:0]   last_q;
  bit            seen_dead;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  task automatic cyc(bit w, bit r, logic [15:0] d, bit rst);
    bit acc_r;
    bit acc_w;
    bus.wrreq = w;
    bus.rdreq = r;
    bus.data  = d;
    aclr      = rst;
    @(posedge clock);
    if (rst) begin
      mq.delete();
      exp_q.delete();
      last_q = '0;
    end else begin
      acc_r = r && (mq.size() > 0);
      acc_w = w && (mq.size() < 1024);
      if (acc_r) begin
        last_q = mq.pop_front();
        exp_q.push_back(last_q);
      end
      if (acc_w) mq.push_back(d);
    end
    @(negedge clock);
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("full", 32'(bus.full), 32'(mq.size() == 1024));
    chk("usedw", 32'(bus.usedw), 32'(mq.size() % 1024));
    chk("almost_empty", 32'(bus.almost_empty), 32'(mq.size() < 504));
`ifdef FIFO_SHOWAHEAD_EN
    if (mq.size() > 0) chk("showahead_head", 32'(bus.q), 32'(mq[0]));
`endif
  endtask

  // Monitor: a read is acknowledged when rdreq meets a non-empty FIFO.
  initial begin
    bit          fire;
    logic [15:0] q_pre;
    logic [15:0] q_obs;
    logic [15:0] e;
    forever begin
      @(posedge clock);
      fire  = bus.rdreq && !bus.empty && !aclr;
      q_pre = bus.q;
      @(negedge clock);
      if (fire) begin
`ifdef FIFO_SHOWAHEAD_EN
        q_obs = q_pre;
`else
        q_obs = bus.q;
`endif
        if (q_obs == 16'hDEAD) seen_dead = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 32'(q_obs), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("q_data", 32'(q_obs), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [15:0] v;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    bus.data  = '0;
    aclr      = 1'b1;
    seen_dead = 1'b0;
    last_q    = '0;

    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("reset_q", 32'(bus.q), 32'h0);

    for (int i = 1; i <= 3; i++) cyc(1, 0, 16'(i), 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    chk("three_empty", 32'(bus.empty), 32'h1);
    chk("three_usedw", 32'(bus.usedw), 32'h0);

    for (int i = 0; i < 504; i++) cyc(1, 0, 16'($urandom), 0);
    chk("ae_at_504", 32'(bus.almost_empty), 32'h0);
    cyc(0, 1, 0, 0);
    chk("ae_at_503", 32'(bus.almost_empty), 32'h1);
    for (int i = 0; i < 503; i++) cyc(0, 1, 0, 0);

    for (int i = 0; i < 1024; i++) begin
      v = 16'($urandom);
      if (v == 16'hDEAD) v = 16'h1234;
      cyc(1, 0, v, 0);
    end
    chk("full_flag", 32'(bus.full), 32'h1);
    cyc(1, 0, 16'hDEAD, 0);
    chk("full_drop_usedw", 32'(bus.usedw), 32'h0);
    cyc(1, 1, 16'hDEAD, 0);
    for (int i = 0; i < 1023; i++) cyc(0, 1, 0, 0);
    chk("no_dead", 32'(seen_dead), 32'h0);

    for (int i = 0; i < 10; i++) cyc(1, 0, 16'($urandom), 0);
    cyc(1, 1, 16'h5A5A, 0);
    chk("rw_10_usedw", 32'(bus.usedw), 32'd10);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
    v = bus.q;
    cyc(1, 1, 16'h7777, 0);
    chk("rw_empty_usedw", 32'(bus.usedw), 32'd1);
`ifndef FIFO_SHOWAHEAD_EN
    chk("rw_empty_q_hold", 32'(bus.q), 32'(v));
`endif
    cyc(0, 1, 0, 0);

    for (int i = 0; i < 300; i++) cyc(1, 0, 16'($urandom), 0);
    cyc(1, 0, 16'hCAFE, 1);
    chk("aclr_empty", 32'(bus.empty), 32'h1);
    chk("aclr_usedw", 32'(bus.usedw), 32'h0);
    cyc(1, 0, 16'hBEEF, 0);
    cyc(0, 1, 0, 0);

    for (int ph = 0; ph < 6; ph++) begin
      int unsigned pw = (ph % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 700; i++)
        cyc($urandom_range(0, 99) < pw,
            $urandom_range(0, 99) < (105 - pw),
            16'($urandom), 0);
    end
    for (int i = 0; i < 1030; i++) cyc(0, 1, 0, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
